// File: rtl/scan_pkg.sv
// Shared XY2-100 definitions: frame geometry, control prefix and the
// helper that builds a complete 20-bit channel word including parity.
package scan_pkg;

    localparam int         XY2_FRAME_BITS = 20;
    localparam int         XY2_DATA_BITS  = 16;
    localparam logic [2:0] XY2_CTRL       = 3'b001;

    typedef struct packed {
        logic [XY2_DATA_BITS-1:0] x;
        logic [XY2_DATA_BITS-1:0] y;
    } xy_pair_t;

    // Parity makes the XOR over all 20 transmitted bits come out to zero.
    function automatic logic [XY2_FRAME_BITS-1:0] xy2_frame(input logic [XY2_DATA_BITS-1:0] data);
        logic parity;
        parity = ^{XY2_CTRL, data};
        return {XY2_CTRL, data, parity};
    endfunction

endpackage

// File: rtl/xy2_bit_timer.sv
// Bit/frame timing for the XY2 link: divides clk into bit periods, tracks the
// bit index within a frame and produces the XY2 clock level.
module xy2_bit_timer
    import scan_pkg::*;
#(
    parameter int HALF_DIV = 25
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       active,
    output logic       bit_start,
    output logic [4:0] bit_idx,
    output logic       xy2_clk_lvl,
    output logic       frame_end
);
    localparam int               DIV_W    = $clog2(2 * HALF_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * HALF_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(HALF_DIV);
    localparam logic [4:0]       BIT_LAST = 5'(XY2_FRAME_BITS - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [4:0]       bit_q, bit_d;
    logic             bit_end;

    assign bit_end     = active && (div_q == DIV_LAST);
    assign frame_end   = bit_end && (bit_q == BIT_LAST);
    // Asserted on the cycle whose clock edge begins a new bit period.
    assign bit_start   = start || (bit_end && !frame_end);
    assign bit_idx     = bit_q;
    assign xy2_clk_lvl = !active || (div_q < DIV_HALF);

    always_comb begin
        div_d = div_q;
        bit_d = bit_q;
        if (start) begin
            div_d = '0;
            bit_d = '0;
        end else if (active) begin
            if (div_q == DIV_LAST) begin
                div_d = '0;
                bit_d = (bit_q == BIT_LAST) ? 5'd0 : bit_q + 5'd1;
            end else begin
                div_d = div_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q <= '0;
            bit_q <= '0;
        end else begin
            div_q <= div_d;
            bit_q <= bit_d;
        end
    end

endmodule

// File: rtl/xy2_100_tx.sv
// XY2-100 galvo transmitter: captures scan coordinates on the send strobe and
// streams them as back-to-back 20-bit frames on the XY2 clock/sync/X/Y lines.
module xy2_100_tx
    import scan_pkg::*;
#(
    parameter int HALF_DIV = 25
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] x_coord,
    input  logic [15:0] y_coord,
    input  logic        xy2_send,
    output logic        xy2_clk,
    output logic        xy2_sync,
    output logic        xy2_x,
    output logic        xy2_y,
    output logic        busy,
    output logic        frame_done,
    output logic        overrun
);
    localparam logic [0:0] ST_IDLE        = 1'b0;
    localparam logic [0:0] ST_SHIFT       = 1'b1;
    localparam logic [4:0] SYNC_LOW_AFTER = 5'(XY2_FRAME_BITS - 2);
    localparam int         NUM_CHAN       = 2;

    logic [0:0] state_q, state_d;
    logic       send_q, rise, load, active;
    logic       pending_q, pending_d;
    logic       overrun_q, overrun_d;
    logic       sync_q, sync_d;
    xy_pair_t   in_pair, load_pair;
    xy_pair_t   buf_q, buf_d, last_q, last_d;
    logic       bit_start, frame_end, clk_lvl;
    logic [4:0] bit_idx;

    logic [XY2_DATA_BITS-1:0] chan_word [NUM_CHAN];
    logic [NUM_CHAN-1:0]      chan_bit;

    assign active  = (state_q == ST_SHIFT);
    assign rise    = xy2_send && !send_q;
    assign load    = enable && (!active || frame_end);
    assign in_pair = {x_coord, y_coord};

    xy2_bit_timer #(
        .HALF_DIV(HALF_DIV)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .start      (load),
        .active     (active),
        .bit_start  (bit_start),
        .bit_idx    (bit_idx),
        .xy2_clk_lvl(clk_lvl),
        .frame_end  (frame_end)
    );

    // A rise coinciding with a load bypasses the buffer so it lands in this frame.
    always_comb begin
        if (rise) begin
            load_pair = in_pair;
        end else if (pending_q) begin
            load_pair = buf_q;
        end else begin
            load_pair = last_q;
        end
    end

    always_comb begin
        pending_d = pending_q;
        buf_d     = buf_q;
        last_d    = last_q;
        overrun_d = 1'b0;
        if (load) begin
            pending_d = 1'b0;
            last_d    = load_pair;
        end else if (rise) begin
            buf_d     = in_pair;
            pending_d = 1'b1;
            overrun_d = pending_q;
        end
    end

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = ST_SHIFT;
        end else if (frame_end) begin
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        sync_d = sync_q;
        if (load) begin
            sync_d = 1'b1;
        end else if (frame_end) begin
            sync_d = 1'b0;
        end else if (bit_start && (bit_idx == SYNC_LOW_AFTER)) begin
            sync_d = 1'b0;
        end
    end

    assign chan_word[0] = load_pair.x;
    assign chan_word[1] = load_pair.y;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CHAN; gi++) begin : g_chan
            logic [XY2_FRAME_BITS-1:0] sr_q, sr_d;

            // MSB of the shift register is the line level; cleared when the link idles.
            always_comb begin
                sr_d = sr_q;
                if (load) begin
                    sr_d = xy2_frame(chan_word[gi]);
                end else if (frame_end) begin
                    sr_d = '0;
                end else if (bit_start) begin
                    sr_d = {sr_q[XY2_FRAME_BITS-2:0], 1'b0};
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    sr_q <= '0;
                end else begin
                    sr_q <= sr_d;
                end
            end

            assign chan_bit[gi] = sr_q[XY2_FRAME_BITS-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            send_q    <= 1'b0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            sync_q    <= 1'b0;
            buf_q     <= '0;
            last_q    <= '0;
        end else begin
            state_q   <= state_d;
            send_q    <= xy2_send;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            sync_q    <= sync_d;
            buf_q     <= buf_d;
            last_q    <= last_d;
        end
    end

    assign xy2_clk    = clk_lvl;
    assign xy2_sync   = sync_q;
    assign xy2_x      = chan_bit[0];
    assign xy2_y      = chan_bit[1];
    assign busy       = active;
    assign frame_done = frame_end;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_xy2_100_tx.sv
// Directed bench for xy2_100_tx: a line receiver decodes frames on XY2 clock
// falling edges and checks them against expected words queued by the stimulus.
module tb_xy2_100_tx;
    localparam int HALF_DIV   = 2;
    localparam int FRAME_CLKS = 40 * HALF_DIV;
    localparam int WAIT_LIMIT = 400;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        xy2_send = 1'b0;
    logic [15:0] x_coord = 16'h0;
    logic [15:0] y_coord = 16'h0;
    logic        xy2_clk, xy2_sync, xy2_x, xy2_y, busy, frame_done, overrun;

    int checks = 0;
    int failures = 0;
    int ovr_cnt = 0;
    int cyc_cnt = 0;
    logic [39:0] exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt++;

    xy2_100_tx #(
        .HALF_DIV(HALF_DIV)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .x_coord   (x_coord),
        .y_coord   (y_coord),
        .xy2_send  (xy2_send),
        .xy2_clk   (xy2_clk),
        .xy2_sync  (xy2_sync),
        .xy2_x     (xy2_x),
        .xy2_y     (xy2_y),
        .busy      (busy),
        .frame_done(frame_done),
        .overrun   (overrun)
    );

    function automatic logic [19:0] exp_frame(input logic [15:0] d);
        int   ones;
        logic p;
        ones = 1;
        for (int i = 0; i < 16; i++) ones += int'(d[i]);
        p = ((ones % 2) == 1);
        return {3'b001, d, p};
    endfunction

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Receiver model: samples data/sync on every XY2 clock falling edge.
    logic        prev_clk = 1'b1, prev_x = 1'b0, prev_y = 1'b0, prev_s = 1'b0;
    logic [19:0] rx_x = '0, rx_y = '0, rx_s = '0;
    logic [39:0] exp_e;
    always @(negedge clk) begin
        if (overrun === 1'b1) ovr_cnt++;
        if (prev_clk === 1'b1 && xy2_clk === 1'b0) begin
            chk("stable_at_fall", {37'd0, xy2_x, xy2_y, xy2_sync}, {37'd0, prev_x, prev_y, prev_s});
            rx_x = {rx_x[18:0], xy2_x};
            rx_y = {rx_y[18:0], xy2_y};
            rx_s = {rx_s[18:0], xy2_sync};
            if (xy2_sync === 1'b0) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    failures++;
                    $error("FAIL unexpected_frame observed_x=%0h observed_y=%0h expected=none", rx_x, rx_y);
                end
                if (exp_q.size() != 0) begin
                    exp_e = exp_q.pop_front();
                    chk("frame_x", {20'd0, rx_x}, {20'd0, exp_e[39:20]});
                    chk("frame_y", {20'd0, rx_y}, {20'd0, exp_e[19:0]});
                    chk("frame_sync", {20'd0, rx_s}, {20'd0, 20'hFFFFE});
                end
            end
        end
        prev_clk = xy2_clk;
        prev_x   = xy2_x;
        prev_y   = xy2_y;
        prev_s   = xy2_sync;
    end

    task automatic pulse_send(input logic [15:0] xv, input logic [15:0] yv);
        x_coord  = xv;
        y_coord  = yv;
        xy2_send = 1'b1;
        repeat (3) @(negedge clk);
        xy2_send = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_done(output int stamp);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_done !== 1'b1 && n < WAIT_LIMIT);
        if (frame_done !== 1'b1) begin
            checks++;
            failures++;
            $error("FAIL done_timeout observed=%0d cycles expected<=%0d", n, WAIT_LIMIT);
        end
        stamp = cyc_cnt;
    endtask

    initial begin
        int t_prev, t_now, o0;

        // Reset state
        repeat (4) @(negedge clk);
        chk("reset_levels", {33'd0, xy2_clk, xy2_sync, xy2_x, xy2_y, busy, frame_done, overrun},
            {33'd0, 7'b1000000});
        reset = 1'b0;

        // 1: capture while idle, then enable -> 0x1234 / 0xABCD
        o0 = ovr_cnt;
        pulse_send(16'h1234, 16'hABCD);
        chk("t1_idle_busy", {39'd0, busy}, 40'd0);
        exp_q.push_back({20'h22468, 20'h3579B});
        enable = 1'b1;
        @(negedge clk);
        chk("t1_first_bit", {35'd0, busy, xy2_clk, xy2_sync, xy2_x, xy2_y}, {35'd0, 5'b11100});
        wait_done(t_prev);
        chk("t1_overrun", 40'(ovr_cnt - o0), 40'd0);

        // 2: repeat of 0x1234 frame, then 0x0000 / 0xFFFF twice
        exp_q.push_back({exp_frame(16'h1234), exp_frame(16'hABCD)});
        @(negedge clk);
        chk("t2_no_gap", {37'd0, busy, xy2_clk, xy2_sync}, {37'd0, 3'b111});
        pulse_send(16'h0000, 16'hFFFF);
        wait_done(t_now);
        chk("t2_period", 40'(t_now - t_prev), 40'(FRAME_CLKS));
        t_prev = t_now;
        exp_q.push_back({20'h20001, 20'h3FFFF});
        exp_q.push_back({20'h20001, 20'h3FFFF});
        wait_done(t_now);
        chk("t2_period_b", 40'(t_now - t_prev), 40'(FRAME_CLKS));
        t_prev = t_now;
        wait_done(t_now);
        chk("t2_period_c", 40'(t_now - t_prev), 40'(FRAME_CLKS));
        t_prev = t_now;

        // 3: two captures in one frame -> one overrun, latest wins
        exp_q.push_back({20'h20001, 20'h3FFFF});
        o0 = ovr_cnt;
        @(negedge clk);
        pulse_send(16'h0100, 16'h0001);
        pulse_send(16'h0200, 16'h0002);
        chk("t3_overrun", 40'(ovr_cnt - o0), 40'd1);
        wait_done(t_now);
        t_prev = t_now;
        exp_q.push_back({exp_frame(16'h0200), exp_frame(16'h0002)});
        wait_done(t_now);
        t_prev = t_now;

        // 4: rise on the load cycle goes straight into that frame
        o0 = ovr_cnt;
        x_coord  = 16'hCAFE;
        y_coord  = 16'h5A5A;
        xy2_send = 1'b1;
        exp_q.push_back({exp_frame(16'hCAFE), exp_frame(16'h5A5A)});
        repeat (3) @(negedge clk);
        xy2_send = 1'b0;
        repeat (2) @(negedge clk);
        pulse_send(16'h1111, 16'h2222);
        chk("t4_overrun", 40'(ovr_cnt - o0), 40'd0);
        wait_done(t_now);
        chk("t4_period", 40'(t_now - t_prev), 40'(FRAME_CLKS));
        t_prev = t_now;
        exp_q.push_back({exp_frame(16'h1111), exp_frame(16'h2222)});
        wait_done(t_now);
        t_prev = t_now;

        // 5: drop enable at bit 7 -> frame completes, then idle
        exp_q.push_back({exp_frame(16'h1111), exp_frame(16'h2222)});
        repeat (1 + 7 * 2 * HALF_DIV) @(negedge clk);
        enable = 1'b0;
        wait_done(t_now);
        chk("t5_period", 40'(t_now - t_prev), 40'(FRAME_CLKS));
        @(negedge clk);
        chk("t5_idle", {34'd0, xy2_clk, xy2_sync, xy2_x, xy2_y, busy, frame_done}, {34'd0, 6'b100000});
        repeat (10) @(negedge clk);
        chk("t5_still_idle", {38'd0, busy, xy2_clk}, {38'd0, 2'b01});

        // 5b: reset at bit 10 with a pending capture -> aborted frame, cleared buffers
        enable = 1'b1;
        @(negedge clk);
        pulse_send(16'h7777, 16'h7777);
        repeat (1 + 10 * 2 * HALF_DIV - 6) @(negedge clk);
        reset  = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        chk("t5_reset_levels", {33'd0, xy2_clk, xy2_sync, xy2_x, xy2_y, busy, frame_done, overrun},
            {33'd0, 7'b1000000});
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_reset_idle", {39'd0, busy}, 40'd0);
        exp_q.push_back({20'h20001, 20'h20001});
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        wait_done(t_now);
        @(negedge clk);
        chk("t5_final_idle", {35'd0, xy2_clk, xy2_sync, xy2_x, xy2_y, busy}, {35'd0, 5'b10000});
        repeat (5) @(negedge clk);
        chk("queue_drained", 40'(exp_q.size()), 40'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
